// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - dm shared defaults, op enumeration and priority decode helper.
package dm_pkg;

    localparam int DM_DATA_W = 16;
    localparam int DM_ADDR_W = 10;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_STORE = 3'd1,
        OP_PUSH  = 3'd2,
        OP_LOAD  = 3'd3,
        OP_POP   = 3'd4
    } op_t;

    // Fixed priority store > push > load > pop; at most one op per cycle.
    function automatic op_t decode_op(
        input logic store,
        input logic push,
        input logic load,
        input logic pop
    );
        if (store)
            return OP_STORE;
        else if (push)
            return OP_PUSH;
        else if (load)
            return OP_LOAD;
        else if (pop)
            return OP_POP;
        else
            return OP_NONE;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// rtl/dm_ram.sv - single write port, single registered read port word memory.
// Optional DM_CLEAR_EN: zero at time zero and whole-array clear on clr.
module dm_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef DM_CLEAR_EN
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end
`else
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end
`endif

    // we and re are never both high, so no read-during-write case exists.
    always_ff @(posedge clk) begin
        if (clr)
            rd_data <= '0;
        else if (re)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/dm.sv
// rtl/dm.sv - data memory: priority decode of store/push/load/pop, address mux, reset.
// Optional DM_CLEAR_EN clears the memory on reset (handled inside dm_ram).
module dm
    import dm_pkg::*;
#(
    parameter int DATA_W = DM_DATA_W,
    parameter int ADDR_W = DM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] rez,
    input  logic [DATA_W-1:0] sp,
    input  logic [DATA_W-1:0] val,
    input  logic              load,
    input  logic              store,
    input  logic              push,
    input  logic              pop,
    output logic [DATA_W-1:0] out
);

    op_t               op;
    logic              use_sp;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              re;
    logic              clr;

    always_comb begin
        op = decode_op(store, push, load, pop);
    end

    // Upper address bits are dropped, giving wrap-around addressing.
    assign use_sp = (op == OP_PUSH) || (op == OP_POP);
    assign addr   = use_sp ? ADDR_W'(sp) : ADDR_W'(rez);

    // Reset suppresses every strobe and clears the read register.
    assign we  = rst_n && ((op == OP_STORE) || (op == OP_PUSH));
    assign re  = rst_n && ((op == OP_LOAD) || (op == OP_POP));
    assign clr = !rst_n;

    dm_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk    (clk),
        .clr    (clr),
        .we     (we),
        .wr_addr(addr),
        .wr_data(val),
        .re     (re),
        .rd_addr(addr),
        .rd_data(out)
    );

endmodule

// File: tb/tb_dm.sv
// tb/tb_dm.sv - table-driven self-checking bench for dm.
module tb_dm;

    logic        clk;
    logic        rst_n;
    logic [15:0] rez;
    logic [15:0] sp;
    logic [15:0] val;
    logic        load;
    logic        store;
    logic        push;
    logic        pop;
    logic [15:0] out;

    int tests;
    int fails;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        store;
        logic        push;
        logic        load;
        logic        pop;
        logic [15:0] rez;
        logic [15:0] sp;
        logic [15:0] val;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    dm u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rez  (rez),
        .sp   (sp),
        .val  (val),
        .load (load),
        .store(store),
        .push (push),
        .pop  (pop),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input string name, input logic r, input logic st, input logic pu,
                       input logic ld, input logic po, input logic [15:0] a_rez,
                       input logic [15:0] a_sp, input logic [15:0] a_val,
                       input logic [15:0] exp);
        vec_t v;
        v.name = name; v.rst_n = r; v.store = st; v.push = pu; v.load = ld; v.pop = po;
        v.rez = a_rez; v.sp = a_sp; v.val = a_val; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: out=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic pu, input logic ld,
                         input logic po, input logic [15:0] a_rez, input logic [15:0] a_sp,
                         input logic [15:0] a_val);
        rst_n = r; store = st; push = pu; load = ld; pop = po;
        rez = a_rez; sp = a_sp; val = a_val;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] exp_after_rst;
    logic [15:0] exp_x30;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0; store = 1'b0; push = 1'b0; load = 1'b0; pop = 1'b0;
        rez = '0; sp = '0; val = '0;
`ifdef DM_CLEAR_EN
        exp_after_rst = 16'h0000;
        exp_x30       = 16'h0000;
`else
        exp_after_rst = 16'hBEEF;
        exp_x30       = 16'h1111;
`endif

        //   name            rst st pu ld po  rez       sp        val       exp
        add("reset",          0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        add("store_holds",    1, 1, 0, 0, 0, 16'h0010, 16'h0000, 16'hBEEF, 16'h0000);
        add("load_beef",      1, 0, 0, 1, 0, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF);
        add("push_holds",     1, 0, 1, 0, 0, 16'h0000, 16'h03FF, 16'h1234, 16'hBEEF);
        add("pop_1234",       1, 0, 0, 0, 1, 16'h0000, 16'h03FF, 16'h0000, 16'h1234);
        add("pop_wrap_sp",    1, 0, 0, 0, 1, 16'h0000, 16'hFFFF, 16'h0000, 16'h1234);
        add("store_x21",      1, 1, 0, 0, 0, 16'h0021, 16'h0000, 16'h0101, 16'h1234);
        add("store_x30",      1, 1, 0, 0, 0, 16'h0030, 16'h0000, 16'h1111, 16'h1234);
        add("store_push",     1, 1, 1, 0, 0, 16'h0020, 16'h0021, 16'h5555, 16'h1234);
        add("load_x20",       1, 0, 0, 1, 0, 16'h0020, 16'h0000, 16'h0000, 16'h5555);
        add("load_x21",       1, 0, 0, 1, 0, 16'h0021, 16'h0000, 16'h0000, 16'h0101);
        add("store_over_ld",  1, 1, 0, 1, 0, 16'h0040, 16'h0000, 16'h4444, 16'h0101);
        add("push_over_ld",   1, 0, 1, 1, 0, 16'h0040, 16'h0041, 16'h4141, 16'h0101);
        add("load_over_pop",  1, 0, 0, 1, 1, 16'h0040, 16'h0041, 16'h0000, 16'h4444);
        add("pop_x41",        1, 0, 0, 0, 1, 16'h0040, 16'h0041, 16'h0000, 16'h4141);
        add("store_wrap",     1, 1, 0, 0, 0, 16'h0405, 16'h0000, 16'hA5A5, 16'h4141);
        add("load_wrap",      1, 0, 0, 1, 0, 16'h0005, 16'h0000, 16'h0000, 16'hA5A5);
        add("idle",           1, 0, 0, 0, 0, 16'h0010, 16'h03FF, 16'hFFFF, 16'hA5A5);
        add("load_again",     1, 0, 0, 1, 0, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF);
        add("rst_clears_out", 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        add("load_after_rst", 1, 0, 0, 1, 0, 16'h0010, 16'h0000, 16'h0000, exp_after_rst);
        add("rst_blocks_ld",  0, 0, 0, 1, 0, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
        add("rst_blocks_st",  0, 1, 0, 0, 0, 16'h0030, 16'h0000, 16'h7777, 16'h0000);
        add("load_x30",       1, 0, 0, 1, 0, 16'h0030, 16'h0000, 16'h0000, exp_x30);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].store, vecs[i].push, vecs[i].load, vecs[i].pop,
                  vecs[i].rez, vecs[i].sp, vecs[i].val);
            check(vecs[i].name, out, vecs[i].exp);
        end

        // Back-to-back write then read, then out must hold over idle cycles.
        drive(1, 1, 0, 0, 0, 16'h0123, 16'h0000, 16'hCAFE);
        drive(1, 0, 0, 1, 0, 16'h0123, 16'h0000, 16'h0000);
        check("b2b_load", out, 16'hCAFE);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
            check("hold_idle", out, 16'hCAFE);
        end

        // Overwrite via push at the same word, then read back via pop and load.
        drive(1, 0, 1, 0, 0, 16'h0000, 16'h0123, 16'h0F0F);
        check("push_hold", out, 16'hCAFE);
        drive(1, 0, 0, 0, 1, 16'h0000, 16'h0123, 16'h0000);
        check("pop_overwrite", out, 16'h0F0F);

        // Reset held for two edges with strobes active, then read.
        drive(0, 1, 1, 0, 0, 16'h0123, 16'h0123, 16'h9999);
        check("rst_hold1", out, 16'h0000);
        drive(0, 0, 0, 0, 1, 16'h0000, 16'h0123, 16'h0000);
        check("rst_hold2", out, 16'h0000);
        drive(1, 0, 0, 1, 0, 16'h0123, 16'h0000, 16'h0000);
`ifdef DM_CLEAR_EN
        check("after_long_rst", out, 16'h0000);
`else
        check("after_long_rst", out, 16'h0F0F);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
